// File: rtl/vga_timing_pkg.sv
// Mode constants and window arithmetic shared by the VGA timing generator.
package vga_timing_pkg;

  // One raster axis: active span plus porches/sync, all in pixels or lines.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  // 640x480@60 (25.175 MHz nominal)
  localparam vga_axis_t VGA640_H  = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam vga_axis_t VGA640_V  = '{active: 480, fp: 10, sync: 2,   bp: 33};
  // 800x600@60 (40 MHz nominal)
  localparam vga_axis_t SVGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam vga_axis_t SVGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  // Positions per line/frame; order on the axis is sync, bp, active, fp.
  function automatic int axis_total(input vga_axis_t a);
    return a.sync + a.bp + a.active + a.fp;
  endfunction

  // First active position on the axis.
  function automatic int axis_act_first(input vga_axis_t a);
    return a.sync + a.bp;
  endfunction

  // Last active position on the axis.
  function automatic int axis_act_last(input vga_axis_t a);
    return a.sync + a.bp + a.active - 1;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// h/v raster position counter. START_H/START_V is both the reset position
// and the position held while en is low, so a second instance can run a
// fixed number of pixels ahead of the first and cross line/frame edges on
// its own wraps.
module vga_raster_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int START_H = 0,
  parameter int START_V = 0,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H0     = CW'(START_H);
  localparam logic [CW-1:0] V0     = CW'(START_V);

  // Advance one pixel per clock; v steps on this counter's own h wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= H0;
      v <= V0;
    end else if (!en) begin
      h <= H0;
      v <= V0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and pixel output stage. A display
// counter drives syncs/de/colour; a lookahead counter LOOKAHEAD pixels
// ahead issues coordinates so the pixel source has that many cycles to
// answer. All outputs are registered from the counter state before the edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LOOKAHEAD = 1,
  parameter int RED_W     = 3,
  parameter int GREEN_W   = 3,
  parameter int BLUE_W    = 2,
  parameter int CW        = 10
) (
  input  logic               clk_25M,
  input  logic               rst_n,
  input  logic               en,
  input  logic [RED_W-1:0]   redIn,
  input  logic [GREEN_W-1:0] greenIn,
  input  logic [BLUE_W-1:0]  blueIn,
  output logic [RED_W-1:0]   vgaRed,
  output logic [GREEN_W-1:0] vgaGreen,
  output logic [BLUE_W-1:0]  vgaBlue,
  output logic               Hsync,
  output logic               Vsync,
  output logic               de,
  output logic [CW-1:0]      x_pos,
  output logic [CW-1:0]      y_pos,
  output logic               coord_valid,
  output logic               line_start,
  output logic               frame_start
);

  localparam vga_axis_t H_AX = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_axis_t V_AX = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  localparam int H_TOTAL = axis_total(H_AX);
  localparam int V_TOTAL = axis_total(V_AX);

  localparam logic [CW-1:0] H_A0 = CW'(axis_act_first(H_AX));
  localparam logic [CW-1:0] H_A1 = CW'(axis_act_last(H_AX));
  localparam logic [CW-1:0] V_A0 = CW'(axis_act_first(V_AX));
  localparam logic [CW-1:0] V_A1 = CW'(axis_act_last(V_AX));
  localparam logic [CW-1:0] H_SE = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SE = CW'(V_SYNC);

  logic [CW-1:0] h, v, lh, lv;
  logic          disp_act, look_act;

  vga_raster_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .START_H(0), .START_V(0), .CW(CW)
  ) u_disp (
    .clk(clk_25M), .rst_n(rst_n), .en(en), .h(h), .v(v)
  );

  vga_raster_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .START_H(LOOKAHEAD), .START_V(0), .CW(CW)
  ) u_look (
    .clk(clk_25M), .rst_n(rst_n), .en(en), .h(lh), .v(lv)
  );

  // Active-window decode for the display and lookahead positions.
  always_comb begin
    disp_act = (h >= H_A0) && (h <= H_A1) && (v >= V_A0) && (v <= V_A1);
    look_act = (lh >= H_A0) && (lh <= H_A1) && (lv >= V_A0) && (lv <= V_A1);
  end

  // Output register stage; en low forces the reset image every edge.
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      Hsync       <= ~HS_POL;
      Vsync       <= ~VS_POL;
      de          <= 1'b0;
      vgaRed      <= '0;
      vgaGreen    <= '0;
      vgaBlue     <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      coord_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      Hsync       <= ~HS_POL;
      Vsync       <= ~VS_POL;
      de          <= 1'b0;
      vgaRed      <= '0;
      vgaGreen    <= '0;
      vgaBlue     <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      coord_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      Hsync       <= (h < H_SE) ? HS_POL : ~HS_POL;
      Vsync       <= (v < V_SE) ? VS_POL : ~VS_POL;
      de          <= disp_act;
      vgaRed      <= disp_act ? redIn   : '0;
      vgaGreen    <= disp_act ? greenIn : '0;
      vgaBlue     <= disp_act ? blueIn  : '0;
      x_pos       <= look_act ? lh - H_A0 : '0;
      y_pos       <= look_act ? lv - V_A0 : '0;
      coord_valid <= look_act;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: three instances (640x480 default, a tiny 15x8 raster with
// LOOKAHEAD=5 and active-low syncs, 800x600 active-low) share clock/reset/en.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n, en;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default 640x480 instance, red loops back x_pos[2:0]
  logic [2:0] d_r, d_g; logic [1:0] d_b;
  logic d_hs, d_vs, d_de, d_cv, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  vga_timing_gen u_def (
    .clk_25M(clk), .rst_n(rst_n), .en(en),
    .redIn(d_x[2:0]), .greenIn(3'd1), .blueIn(2'd1),
    .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b),
    .Hsync(d_hs), .Vsync(d_vs), .de(d_de),
    .x_pos(d_x), .y_pos(d_y), .coord_valid(d_cv),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // tiny raster: H 3/2/8/2 = 15, V 2/1/4/1 = 8, frame 120
  logic [2:0] l_r, l_g; logic [1:0] l_b;
  logic l_hs, l_vs, l_de, l_cv, l_ls, l_fs;
  logic [9:0] l_x, l_y;
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(5)
  ) u_la (
    .clk_25M(clk), .rst_n(rst_n), .en(en),
    .redIn(3'd5), .greenIn(3'd2), .blueIn(2'd1),
    .vgaRed(l_r), .vgaGreen(l_g), .vgaBlue(l_b),
    .Hsync(l_hs), .Vsync(l_vs), .de(l_de),
    .x_pos(l_x), .y_pos(l_y), .coord_valid(l_cv),
    .line_start(l_ls), .frame_start(l_fs)
  );

  // 800x600, active-low syncs, 1056x628
  logic [2:0] s_r, s_g; logic [1:0] s_b;
  logic s_hs, s_vs, s_de, s_cv, s_ls, s_fs;
  logic [10:0] s_x, s_y;
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(11)
  ) u_svga (
    .clk_25M(clk), .rst_n(rst_n), .en(en),
    .redIn(3'd3), .greenIn(3'd3), .blueIn(2'd3),
    .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b),
    .Hsync(s_hs), .Vsync(s_vs), .de(s_de),
    .x_pos(s_x), .y_pos(s_y), .coord_valid(s_cv),
    .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n display positions on the tiny raster from a fresh start and
  // reports the first de and first coord_valid positions.
  task automatic run_small(input int n, output int de_first, output int cv_first,
                           output int cv_x, output int cv_y);
    de_first = -1; cv_first = -1; cv_x = -1; cv_y = -1;
    for (int p = 0; p < n; p++) begin
      if (l_de && de_first < 0) de_first = p;
      if (l_cv && cv_first < 0) begin
        cv_first = p; cv_x = int'(l_x); cv_y = int'(l_y);
      end
      tick();
    end
  endtask

  int def_hs, def_vs, def_de35, def_r0, def_r639, def_de_pre, def_x_pre, def_cv_pre;
  int la_fs2, la_de_first, la_cv_first, la_cvx, la_cvy, la_de_cnt, la_hs_low, la_vs_low;
  int la_col_bad, la_x97, la_y97, la_cv97, la_x60, la_y60, la_next, la_nx, la_ny;
  int sv_hs_low, sv_ls, sv_de27, sv_vs_low;
  int a, b, c, e;

  initial begin
    rst_n = 1'b0; en = 1'b0;
    #12;
    chk("rst_def_hs", d_hs, 0);
    chk("rst_def_vs", d_vs, 0);
    chk("rst_la_hs", l_hs, 1);
    chk("rst_la_vs", l_vs, 1);
    chk("rst_def_de", d_de, 0);
    chk("rst_def_cv", d_cv, 0);
    chk("rst_la_x", l_x, 0);
    chk("rst_def_fs", d_fs, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("en0_la_fs", l_fs, 0);
    chk("en0_la_hs", l_hs, 1);

    en = 1'b1;
    tick();
    chk("first_def_hs", d_hs, 1);
    chk("first_def_vs", d_vs, 1);
    chk("first_def_fs", d_fs, 1);
    chk("first_def_ls", d_ls, 1);
    chk("first_la_hs", l_hs, 0);
    chk("first_la_fs", l_fs, 1);
    chk("first_sv_vs", s_vs, 0);

    def_hs = 0; def_vs = 0; def_de35 = 0; def_r0 = -1; def_r639 = -1;
    def_de_pre = -1; def_x_pre = -1; def_cv_pre = -1;
    la_fs2 = -1; la_de_first = -1; la_cv_first = -1; la_cvx = -1; la_cvy = -1;
    la_de_cnt = 0; la_hs_low = 0; la_vs_low = 0; la_col_bad = 0;
    la_x97 = -1; la_y97 = -1; la_cv97 = -1; la_x60 = -1; la_y60 = -1;
    la_next = -1; la_nx = -1; la_ny = -1;
    sv_hs_low = 0; sv_ls = -1; sv_de27 = 0; sv_vs_low = 0;

    for (int p = 0; p < 29600; p++) begin
      if (p < 800 && d_hs) def_hs++;
      if (p < 28800 && d_vs) def_vs++;
      if (p >= 28000 && p < 28800 && d_de) def_de35++;
      if (p == 28143) begin def_de_pre = d_de; def_x_pre = d_x; def_cv_pre = d_cv; end
      if (p == 28144) def_r0 = d_r;
      if (p == 28783) def_r639 = d_r;

      if (p > 0 && l_fs && la_fs2 < 0) la_fs2 = p;
      if (l_de && la_de_first < 0) la_de_first = p;
      if (l_cv && la_cv_first < 0) begin la_cv_first = p; la_cvx = l_x; la_cvy = l_y; end
      if (p < 120) begin
        if (l_de) la_de_cnt++;
        if (!l_hs) la_hs_low++;
        if (!l_vs) la_vs_low++;
      end
      if (l_r !== (l_de ? 3'd5 : 3'd0)) la_col_bad++;
      if (p == 60) begin la_x60 = l_x; la_y60 = l_y; end
      if (p == 97) begin la_x97 = l_x; la_y97 = l_y; la_cv97 = l_cv; end
      if (p > 97 && l_cv && la_next < 0) begin la_next = p; la_nx = l_x; la_ny = l_y; end

      if (p < 1056 && !s_hs) sv_hs_low++;
      if (p == 1056) sv_ls = s_ls;
      if (p >= 27 * 1056 && p < 28 * 1056 && s_de) sv_de27++;
      if (p < 28 * 1056 && !s_vs) sv_vs_low++;
      tick();
    end

    chk("def_hs_hi_per_line", def_hs, 96);
    chk("def_vs_hi_cycles", def_vs, 1600);
    chk("def_de_line35", def_de35, 640);
    chk("def_de_before_active", def_de_pre, 0);
    chk("def_coord_x0_issue", def_x_pre, 0);
    chk("def_coord_cv_issue", def_cv_pre, 1);
    chk("def_red_first", def_r0, 0);
    chk("def_red_640th", def_r639, 7);
    chk("la_frame_period", la_fs2, 120);
    chk("la_de_first", la_de_first, 50);
    chk("la_cv_first", la_cv_first, 45);
    chk("la_cv_first_x", la_cvx, 0);
    chk("la_cv_first_y", la_cvy, 0);
    chk("la_de_per_frame", la_de_cnt, 32);
    chk("la_hs_low_per_frame", la_hs_low, 24);
    chk("la_vs_low_per_frame", la_vs_low, 30);
    chk("la_colour_blank", la_col_bad, 0);
    chk("la_x_line1", la_x60, 0);
    chk("la_y_line1", la_y60, 1);
    chk("la_last_x", la_x97, 7);
    chk("la_last_y", la_y97, 3);
    chk("la_last_cv", la_cv97, 1);
    chk("la_next_pos", la_next, 165);
    chk("la_next_x", la_nx, 0);
    chk("la_next_y", la_ny, 0);
    chk("sv_hs_low_per_line", sv_hs_low, 128);
    chk("sv_line_period", sv_ls, 1);
    chk("sv_de_line27", sv_de27, 800);
    chk("sv_vs_low_cycles", sv_vs_low, 4224);

    // en dropped mid-frame while the tiny raster is inside its active window
    chk("pre_drop_la_de", l_de, 1);
    en = 1'b0;
    tick();
    chk("drop_la_de", l_de, 0);
    chk("drop_la_hs", l_hs, 1);
    chk("drop_la_vs", l_vs, 1);
    chk("drop_la_cv", l_cv, 0);
    chk("drop_la_red", l_r, 0);
    chk("drop_def_hs", d_hs, 0);
    tick(); tick();
    chk("drop_la_fs", l_fs, 0);
    en = 1'b1;
    tick();
    chk("restart_la_fs", l_fs, 1);
    chk("restart_def_fs", d_fs, 1);
    chk("restart_la_ls", l_ls, 1);
    run_small(53, a, b, c, e);
    chk("restart_de_first", a, 50);
    chk("restart_cv_first", b, 45);

    // outputs now show position 53: line 3, h=8, inside the active window
    chk("pre_rst_la_de", l_de, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_la_de", l_de, 0);
    chk("arst_la_red", l_r, 0);
    chk("arst_la_hs", l_hs, 1);
    chk("arst_la_vs", l_vs, 1);
    chk("arst_def_hs", d_hs, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rerst_la_fs", l_fs, 1);
    chk("rerst_la_hs", l_hs, 0);
    chk("rerst_def_vs", d_vs, 1);
    run_small(60, a, b, c, e);
    chk("rerst_de_first", a, 50);
    chk("rerst_cv_first", b, 45);
    chk("rerst_cv_x", c, 0);
    chk("rerst_cv_y", e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage, the successor to the fixed 640x480 driver. It generates hsync/vsync/data-enable for any mode given by porch/sync/active parameters, issues pixel coordinates a configurable number of cycles ahead of display so upstream frame-buffer or sprite pipelines of any depth can be absorbed, and blanks colour outside the active window. It sits between the pixel-source logic and the board VGA pins.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 1 / 1, sync level during the sync window (1 = active high)
- LOOKAHEAD, 1, cycles from coordinate issue to colour sample; range 1..H_TOTAL-1
- RED_W / GREEN_W / BLUE_W, 3 / 3 / 2, colour channel widths
- CW, 10, width of x_pos/y_pos; must hold max(H_TOTAL, V_TOTAL)-1
- clk_25M  in  1  pixel clock (name kept; actual rate per mode)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable
- redIn / greenIn / blueIn  in  RED_W / GREEN_W / BLUE_W  pixel colour for the coordinate issued LOOKAHEAD cycles earlier
- vgaRed / vgaGreen / vgaBlue  out  RED_W / GREEN_W / BLUE_W  registered colour, 0 when blanked
- Hsync / Vsync  out  1  registered syncs
- de  out  1  registered active-video flag
- x_pos / y_pos  out  CW  requested pixel coordinate
- coord_valid  out  1  x_pos/y_pos name an active pixel
- line_start / frame_start  out  1  one-cycle pulses at display h=0 / at h=0,v=0

## Operation
- One clock; reset is asynchronous and active-low.
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Line order: sync, back porch, active, front porch. Horizontal active window [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1]; vertical analogous.
- Display counter (h,v): h wraps at H_TOTAL-1, v increments on h wrap and wraps at V_TOTAL-1.
- Lookahead counter (lh,lv): identical wrap rules, held exactly LOOKAHEAD positions ahead of (h,v), crossing line and frame boundaries correctly (lv advances on lh wrap, not on h wrap).
- x_pos = lh - (H_SYNC+H_BP), y_pos = lv - (V_SYNC+V_BP), truncated to CW, when (lh,lv) is active; else both 0 and coord_valid = 0.
- Hsync = HS_POL when h < H_SYNC, else ~HS_POL; Vsync likewise with v < V_SYNC.
- de = 1 iff (h,v) active; colour outputs = inputs when de else 0.
- en low: both counters held at reset position, outputs at reset values. en rising: counting starts from reset position on the next edge; en falling mid-frame: abort at next edge, no frame completion.
- Reset values: counters (0,0) and (LOOKAHEAD,0); Hsync=~HS_POL, Vsync=~VS_POL; de, colours, x_pos, y_pos, coord_valid, pulses = 0.

## Timing
- All outputs registered; values after edge k reflect counter state before edge k.
- First edge with en=1 after reset: Hsync=HS_POL, Vsync=VS_POL, frame_start=1, line_start=1.
- Coordinate (x,y) with coord_valid at edge k; colour inputs sampled at edge k+LOOKAHEAD, where de=1 for that pixel.
- Async reset mid-frame: outputs reach reset values immediately, not at a clock edge.
- Frame period H_TOTAL*V_TOTAL cycles exactly; frame_start spacing checked against it.

## Structure
- Package vga_timing_pkg: mode constants (640x480@60, 800x600@60) and a localparam-style function computing totals and window bounds.
- Sub-module vga_raster_counter (h/v pair with start-offset parameter), instantiated twice: display and lookahead.

## Test plan
- Default mode, en=1 from reset -> frame_start every 420000 cycles; Hsync high for 96 of every 800 cycles; Vsync high for 2 of 525 lines.
- Default mode, redIn=x[2:0] loop-back -> vgaRed at first active pixel of line 35 = 0, 640th = 7 (639 mod 8), de high for 640 cycles per active line.
- LOOKAHEAD=5 -> coord_valid (0,0) exactly 5 edges before de first high; last-pixel coordinate (639,479) followed by (0,0) of next frame with no gap in y.
- HS_POL=0, VS_POL=0, 800x600 params -> syncs active low, totals 1056x628, de count 480000 per frame.
- en dropped at line 200 then raised -> outputs blank immediately after next edge, restart with frame_start on first edge after en high.
- rst_n pulsed low mid-active-line -> Hsync/Vsync to inactive, colours 0 without clock edge; restart identical to power-on.
